rr_arb_mux: RTL
===============

// Module: rr_arb_mux
// PURPOSE
//  Parametrised N_CH:1 registered channel multiplexer with round-robin arbitration
//  and valid/ready handshakes on every input and on the output. It merges several
//  WIDTH-bit producer streams, e.g. ALU result sources, onto one registered output bus.
//  The select is chosen by an internal fair arbiter, not by external select bits.
// PARAMETERS
//  WIDTH  64  data bits per channel
//  N_CH   4   number of input channels; >=1, need not be a power of 2
//  SEL_W  (N_CH>1 ? $clog2(N_CH) : 1)  derived width of the channel index; do not override
// PORTS
//  clk        in   1            single clock; all state on posedge
//  reset      in   1            asynchronous, active-high; clears all state immediately
//  in_data    in   N_CH*WIDTH   channel k occupies bits [k*WIDTH +: WIDTH]
//  in_valid   in   N_CH         channel k offers a beat
//  in_ready   out  N_CH         channel k beat accepted this cycle when valid&ready
//  in_last    in   N_CH         end-of-packet flag per channel; present only with RR_ARB_MUX_LOCK_EN
//  out_data   out  WIDTH        registered selected data
//  out_sel    out  SEL_W        registered index of the channel that supplied out_data
//  out_valid  out  1            out_data/out_sel hold a beat
//  out_ready  in   1            consumer accepts the beat this cycle
// BEHAVIOUR
//  - Reset (async): out_valid=0, out_data=0, out_sel=0, ptr=0, lock state=IDLE.
//    in_ready=0 for all channels while reset is high. A held beat is discarded.
//  - load = !out_valid || out_ready. The output register may accept a new beat this cycle.
//  - grant: one-hot, combinational. It selects the first k with in_valid[k]=1, scanning
//    ptr, ptr+1, ... modulo N_CH. It is 0 when no channel is valid.
//  - in_ready[k] = load && grant[k]. At most one bit is set. in_ready may depend on
//    in_valid. Producers must not make in_valid depend on in_ready.
//  - On accept of channel g: out_data<=in_data[g], out_sel<=g, out_valid<=1, ptr<=(g+1)%N_CH.
//    When g=N_CH-1, ptr wraps to 0.
//  - When load=1 and there is no grant: out_valid<=0. out_data and out_sel keep their values.
//  - When load=0 (out_valid && !out_ready): all outputs are held stable and all in_ready are 0.
//  - Latency: 1 cycle from input accept to out_valid. Throughput: 1 beat/cycle when
//    out_ready is held at 1. Output drain and new load in the same cycle are legal.
//  - N_CH=1: ptr stays 0 and the block behaves as a 1-deep registered pipe stage.
//  - ptr changes only on an accept. Idle cycles and stalled cycles do not move it.
// CONFIGURATION
//  RR_ARB_MUX_LOCK_EN defined:
//   - Adds port in_last and a two-state FSM: IDLE and LOCKED(lch).
//   - IDLE: normal round-robin arbitration.
//     - Accept of channel g with in_last[g]=0: go to LOCKED(g); ptr is not advanced.
//     - Accept of channel g with in_last[g]=1: stay IDLE; ptr<=(g+1)%N_CH.
//   - LOCKED(lch): grant = in_valid[lch] only. All other channels stall even when valid.
//     - Accept of lch with in_last[lch]=1: go to IDLE; ptr<=(lch+1)%N_CH.
//   - Reset in either state: go to IDLE.
//  RR_ARB_MUX_LOCK_EN undefined:
//   - No in_last port and no FSM. Every beat is arbitrated independently.
// TESTING  (WIDTH=8, N_CH=4 unless stated)
//  1 Reset: reset=1 with in_valid=4'hF, out_ready=1 -> in_ready=0, out_valid=0,
//    out_sel=0, out_data=0. Release reset -> first output beat is out_sel=0.
//  2 Rotation: all channels valid, in_data[k]=8'hA0+k, out_ready=1 -> out_sel 0,1,2,3,0
//    and out_data A0,A1,A2,A3,A0 on consecutive cycles.
//  3 Backpressure: only ch2 valid with data 8'h5C; out_ready=0 for 3 cycles -> out_valid=1,
//    out_data=5C held, in_ready=0 on cycles 2-3. Set out_ready=1 -> next beat is accepted.
//  4 Fairness: only ch1 and ch3 held valid, out_ready=1 -> out_sel 1,3,1,3.
//    Then assert reset mid-stream -> out_valid=0 asynchronously.
//  5 Wrap: N_CH=3 build, all channels valid -> out_sel 0,1,2,0,1.
//  6 Lock (RR_ARB_MUX_LOCK_EN): ch0 sends 3 beats with in_last on beat 3; ch1 valid
//    throughout -> out_sel 0,0,0,1 and in_ready[1]=0 during the ch0 packet.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N_CH:1 registered channel mux with a round-robin arbiter and valid/ready on every port.
// Define RR_ARB_MUX_LOCK_EN to add in_last and hold the grant on one channel until its last beat.
module rr_arb_mux #(
    parameter int WIDTH = 64,
    parameter int N_CH  = 4,
    parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [N_CH-1:0]       in_last,
`endif
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load;
    logic             accept;
    logic             hi_found, lo_found, rr_found;
    logic [SEL_W-1:0] hi_sel, lo_sel, rr_sel;
    logic             gnt_found;
    logic [SEL_W-1:0] gnt_sel;
    logic [SEL_W-1:0] nxt_ptr;
    logic [N_CH-1:0]  grant;
    logic [WIDTH-1:0] gnt_data;

    assign load = !valid_q || out_ready;

    // Lowest valid index at or above ptr wins; otherwise the lowest valid index overall.
    always_comb begin : rr_scan
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        hi_found = 1'b0;
        hi_sel   = '0;
        lo_found = 1'b0;
        lo_sel   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (in_valid[k]) begin
                lo_found = 1'b1;
                lo_sel   = SEL_W'(k);
                if (k >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_sel   = SEL_W'(k);
                end
            end
        end
        rr_found = hi_found || lo_found;
        rr_sel   = hi_found ? hi_sel : lo_sel;
    end

`ifdef RR_ARB_MUX_LOCK_EN
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] lch_q, lch_d;
    logic             lch_valid;
    logic             gnt_last;

    always_comb begin : lock_lookup
        lch_valid = 1'b0;
        gnt_last  = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (lch_q == SEL_W'(k)) lch_valid = in_valid[k];
            if (gnt_sel == SEL_W'(k)) gnt_last = in_last[k];
        end
    end

    assign gnt_found = (state_q == ST_LOCKED) ? lch_valid : rr_found;
    assign gnt_sel   = (state_q == ST_LOCKED) ? lch_q : rr_sel;
`else
    assign gnt_found = rr_found;
    assign gnt_sel   = rr_sel;
`endif

    always_comb begin : grant_decode
        grant    = '0;
        gnt_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt_found && (gnt_sel == SEL_W'(k))) begin
                grant[k] = 1'b1;
                gnt_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Gating with reset keeps in_ready low while the async reset is asserted.
    assign accept   = load && gnt_found && !reset;
    assign in_ready = accept ? grant : '0;
    assign nxt_ptr  = (gnt_sel == SEL_W'(N_CH - 1)) ? '0 : gnt_sel + SEL_W'(1);

    always_comb begin : next_state
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef RR_ARB_MUX_LOCK_EN
        state_d = state_q;
        lch_d   = lch_q;
`endif
        if (load) begin
            valid_d = accept;
            if (accept) begin
                data_d = gnt_data;
                sel_d  = gnt_sel;
`ifdef RR_ARB_MUX_LOCK_EN
                case (state_q)
                    ST_IDLE: begin
                        if (gnt_last) begin
                            ptr_d = nxt_ptr;
                        end else begin
                            state_d = ST_LOCKED;
                            lch_d   = gnt_sel;
                        end
                    end
                    ST_LOCKED: begin
                        if (gnt_last) begin
                            state_d = ST_IDLE;
                            ptr_d   = nxt_ptr;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
`else
                ptr_d = nxt_ptr;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
            state_q <= ST_IDLE;
            lch_q   <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef RR_ARB_MUX_LOCK_EN
            state_q <= state_d;
            lch_q   <= lch_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule
